decoder_onehot_seq: RTL and testbench
=====================================

Name: decoder_onehot_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. It is the sequential successor to the 3-to-8 combinational decoder.
- Output is registered and uses a valid/ready handshake, so it can sit between pipeline stages. Illegal codes are range-checked.
- An auto-scan mode walks the one-hot output through all legal codes at a programmable rate. Used for select-line generation and LED/strobe sequencing.

Parameters:
- IN_W, 3, width of binary code input.
- NUM_OUT, 8, number of one-hot outputs; legal range 2 to 2**IN_W. Codes >= NUM_OUT are illegal.
- SCAN_DIV, 4, clock cycles between scan steps in SCAN mode; legal range >= 1.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = DIRECT, 1 = SCAN; sampled only in IDLE.
- in_valid  input  1  data_in is valid (DIRECT mode).
- in_ready  output  1  block can accept data_in.
- data_in  input  IN_W  binary code.
- data_out  output  NUM_OUT  registered one-hot result.
- out_valid  output  1  data_out is valid.
- out_ready  input  1  downstream accepts data_out.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - data_out = 0, out_valid = 0, in_ready = 0 during the reset cycle.
  - FSM = IDLE, scan counter = 0, divider = 0.
  - Reset mid-transfer discards any pending output; no partial result survives.
- FSM states: IDLE, DIRECT, SCAN. IDLE lasts exactly one cycle after reset deassertion, then:
  - mode = 0 -> DIRECT.
  - mode = 1 -> SCAN.
- Mode switching:
  - A change on mode is honoured only when out_valid = 0, or when out_valid & out_ready in the same cycle (the pending word drains first).
  - The FSM returns through IDLE for one cycle on every mode switch.
- Output handshake (both modes):
  - A word transfers when out_valid & out_ready.
  - data_out and out_valid are held stable while out_valid = 1 and out_ready = 0.
- DIRECT mode:
  - in_ready = !out_valid | out_ready (one-deep, full throughput).
  - On in_valid & in_ready, the next cycle gives data_out = 1 << data_in and out_valid = 1. Latency is 1 cycle.
  - Simultaneous accept and drain in one cycle loads the new word with no bubble.
  - Illegal code (data_in >= NUM_OUT) gives data_out = 0 with out_valid = 1; the word is still delivered.
- SCAN mode:
  - in_ready = 0; data_in is ignored.
  - The divider counts 0..SCAN_DIV-1. On its terminal count, if no word is pending or one drains that cycle, a word is loaded:
    - data_out = 1 << scan counter, out_valid = 1.
    - The scan counter increments and wraps from NUM_OUT-1 to 0.
  - Backpressure: the divider saturates at terminal count and the counter does not advance; no code is ever skipped.
  - First word appears SCAN_DIV cycles after entering SCAN. With out_ready held at 1, out_valid is a single-cycle pulse every SCAN_DIV cycles; SCAN_DIV = 1 gives continuous valid.
  - Leaving SCAN resets the scan counter and divider to 0.
- Widths: the shift is computed in NUM_OUT bits. Only bits [NUM_OUT-1:0] exist, and no X may propagate for illegal codes.

Optional Feature:
- Macro: DECODER_ONEHOT_ERR_EN.
- When defined:
  - Adds output err (1 bit), registered alongside data_out. err = 1 for an illegal DIRECT code and is valid only with out_valid.
  - Adds output err_cnt (8 bits): a saturating count (stops at 255) of delivered illegal words, cleared only by rst.
- When undefined:
  - Neither port exists.
  - Illegal codes silently produce data_out = 0; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles while in_valid = 1, data_in = 3'b101 -> data_out = 8'h00, out_valid = 0 throughout reset; no word is emitted after release until a new accept.
- DIRECT sweep: NUM_OUT = 8, out_ready = 1, back-to-back data_in 0..7 -> data_out = 8'h01, 02, 04 ... 80, each 1 cycle after accept; in_ready stays 1 (no bubbles).
- Backpressure: hold out_ready = 0 after data_in = 3 is accepted -> data_out = 8'h08 held, in_ready = 0; data_in = 6 offered meanwhile is not accepted until out_ready = 1. Then 8'h08 transfers and 8'h40 follows the next cycle.
- Illegal code: NUM_OUT = 6, data_in = 7 -> data_out = 6'b000000 with out_valid = 1. With DECODER_ONEHOT_ERR_EN: err = 1 and err_cnt increments from 0 to 1.
- SCAN wrap: mode = 1, SCAN_DIV = 4, NUM_OUT = 6, out_ready = 1 -> one out_valid pulse every 4 cycles with data_out sequence 01, 02, 04, 08, 10, 20, 01 (wraps after 6 words).
- Mode switch under backpressure: in SCAN with word 8'h04 pending and out_ready = 0, set mode = 0 -> 8'h04 is held until out_ready = 1. Then one IDLE cycle, then in_ready = 1 in DIRECT, and the scan counter reads 0 on re-entry to SCAN.

Source files
------------

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: registered binary-to-one-hot decoder with a
// valid/ready output stage and an auto-scan mode.
//
// Optional feature macro: DECODER_ONEHOT_ERR_EN (adds err / err_cnt).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = DIRECT, 1 = SCAN (a change is taken once the output drains)
//   in_valid   data_in valid (DIRECT)
//   in_ready   block can accept data_in
//   data_in    binary code
//   data_out   registered one-hot word (all zero for an illegal code)
//   out_valid  data_out valid
//   out_ready  downstream accepts data_out
//   err        (optional) word came from an illegal DIRECT code
//   err_cnt    (optional) saturating count of delivered illegal words
module decoder_onehot_seq #(
  parameter int IN_W     = 3,
  parameter int NUM_OUT  = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    data_in,
  output logic [NUM_OUT-1:0] data_out,
  output logic               out_valid,
`ifdef DECODER_ONEHOT_ERR_EN
  output logic               err,
  output logic [7:0]         err_cnt,
`endif
  input  logic               out_ready
);

  localparam int CNT_W = $clog2(NUM_OUT);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OUT - 1);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCAN_DIV - 1);
  localparam logic [IN_W:0]    CODE_LIM = (IN_W + 1)'(NUM_OUT);

  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_e;

  state_e               state_q, state_d;
  logic [NUM_OUT-1:0]   data_q, data_d;
  logic                 vld_q, vld_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 err_q, err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic                 drain_ok;
  logic                 illegal;

  // Per-bit compare keeps every output bit defined for out-of-range codes.
  function automatic logic [NUM_OUT-1:0] onehot(input logic [IN_W:0] code);
    logic [NUM_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (code == (IN_W + 1)'(i)) r[i] = 1'b1;
    return r;
  endfunction

  // No word is left pending after this cycle.
  assign drain_ok = !vld_q || out_ready;
  assign illegal  = {1'b0, data_in} >= CODE_LIM;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a mode change leaves through IDLE once the output is free.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = mode ? S_SCAN : S_DIRECT;
      S_DIRECT: if (mode && drain_ok)  state_d = S_IDLE;
      S_SCAN:   if (!mode && drain_ok) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs. in_ready is withheld while a mode change is pending so no new
  // word can be captured behind the one that is draining.
  always_comb begin
    in_ready  = (state_q == S_DIRECT) && !mode && drain_ok && !rst;
    data_out  = data_q;
    out_valid = vld_q;
  end

  // Datapath
  always_comb begin
    data_d    = data_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;

    if (vld_q && out_ready) vld_d = 1'b0;

    unique case (state_q)
      S_DIRECT: begin
        if (in_valid && in_ready) begin
          data_d = onehot({1'b0, data_in});
          vld_d  = 1'b1;
          err_d  = illegal;
        end
      end
      S_SCAN: begin
        if (state_d != S_SCAN) begin
          cnt_d = '0;
          div_d = '0;
        end else if (div_q == DIV_TC) begin
          // Divider parks at terminal count under backpressure.
          if (drain_ok) begin
            data_d = onehot((IN_W + 1)'(cnt_q));
            vld_d  = 1'b1;
            err_d  = 1'b0;
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            div_d  = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
        div_d = '0;
      end
    endcase

    if (vld_q && out_ready && err_q && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef DECODER_ONEHOT_ERR_EN
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq (NUM_OUT = 6, SCAN_DIV = 4): a queue of
// expected words is filled by stimulus and drained by an output monitor.
module tb_decoder_onehot_seq;

  localparam int IN_W = 3;
  localparam int NO   = 6;
  localparam int SD   = 4;

  logic            clk;
  logic            rst;
  logic            mode;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] data_in;
  logic [NO-1:0]   data_out;
  logic            out_valid;
  logic            out_ready;
`ifdef DECODER_ONEHOT_ERR_EN
  logic            err;
  logic [7:0]      err_cnt;
`endif

  decoder_onehot_seq #(.IN_W(IN_W), .NUM_OUT(NO), .SCAN_DIV(SD)) u_dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid),
`ifdef DECODER_ONEHOT_ERR_EN
    .err(err), .err_cnt(err_cnt),
`endif
    .out_ready(out_ready)
  );

  typedef struct {
    logic [NO-1:0] word;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: code k selects output k; codes beyond the outputs give none.
  function automatic exp_t ref_word(input int code);
    exp_t e;
    e.word = (code < NO) ? NO'(2 ** code) : '0;
    e.err  = (code >= NO);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input side of the scoreboard.
  always @(negedge clk)
    if (!rst && in_valid && in_ready) sb_q.push_back(ref_word(int'(data_in)));

  // Output monitor: pops on every transfer, checks stability under stall.
  logic          hold_pend = 1'b0;
  logic [NO-1:0] hold_data;
  int            model_errs = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend  = 1'b0;
      model_errs = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", data_out, hold_data);
      end
      hold_pend = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word got=%0h exp=none at %0t", data_out, $time);
          end else begin
            tests--;
            e = sb_q.pop_front();
            check("word", data_out, e.word);
`ifdef DECODER_ONEHOT_ERR_EN
            check("err", err, e.err);
            check("err_cnt", err_cnt, model_errs);
            if (e.err && model_errs < 255) model_errs++;
`endif
          end
        end else begin
          hold_pend = 1'b1;
          hold_data = data_out;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap;
    exp_t e;

    // Reset with a valid input pending.
    rst = 1; mode = 0; in_valid = 1; data_in = 3'b101; out_ready = 0;
    #1;
    check("rst_in_ready_comb", in_ready, 0);
    repeat (2) begin
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_in_ready", in_ready, 0);
    end
    rst = 0; in_valid = 0;
    tick();
    check("idle_one_cycle", in_ready, 1);
    repeat (3) begin
      tick();
      check("no_word_after_rst", out_valid, 0);
    end

    // Back-to-back sweep of every code, including the illegal ones.
    out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      data_in = 3'(c); in_valid = 1;
      #1;
      check("sweep_in_ready", in_ready, 1);
      tick();
      check("sweep_latency", out_valid, 1);
    end
    in_valid = 0;
    repeat (2) tick();
    check("sweep_drained", sb_q.size(), 0);

    // Backpressure: code 3 held, code 5 waits.
    data_in = 3; in_valid = 1;
    tick();
    out_ready = 0; data_in = 5;
    repeat (4) begin
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_data", data_out, 8'h08);
    end
    out_ready = 1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("bp_next", data_out, 8'h20);
    tick();

    // Reset while a word is stalled.
    data_in = 2; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    sb_q.delete();
    check("midrst_valid", out_valid, 0);
    tick();
    check("midrst_valid2", out_valid, 0);

    // Random DIRECT traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) tick();
    check("direct_drained", sb_q.size(), 0);

    // SCAN: latency, pulse spacing and wrap.
    for (int k = 0; k < 80; k++) begin
      e.word = NO'(2 ** (k % NO)); e.err = 1'b0;
      sb_q.push_back(e);
    end
    mode = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check("scan_first_lat", n, 2 + SD);
    gap = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      gap++;
      if (out_valid) begin
        check("scan_gap", gap, SD);
        gap = 0;
      end
    end
    check("scan_in_ready", in_ready, 0);

    // SCAN under random backpressure: no code skipped.
    for (int i = 0; i < 150; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 0;

    // Mode switch with a stalled word.
    out_ready = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("switch_word_pending", out_valid, 1);
    mode = 0;
    repeat (3) begin
      tick();
      check("switch_hold_valid", out_valid, 1);
      check("switch_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    check("switch_idle_valid", out_valid, 0);
    check("switch_idle_ready", in_ready, 0);
    sb_q.delete();
    tick();
    check("switch_direct_ready", in_ready, 1);

    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 0;
    repeat (3) tick();
    check("direct2_drained", sb_q.size(), 0);

    // Re-entry to SCAN restarts at output 0.
    for (int k = 0; k < 10; k++) begin
      e.word = NO'(2 ** (k % NO)); e.err = 1'b0;
      sb_q.push_back(e);
    end
    mode = 1;
    repeat (30) tick();
    check("reentry_words", (sb_q.size() < 10), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
